booth_seq_mult: RTL
===================

Name: booth_seq_mult

Overview:
- Multi-cycle radix-2 Booth multiplier with architectural HI/LO registers, for MULT/MULTU in the micro MIPS core.
- Sits beside the combinational boot_prod and feeds the MFHI/MFLO writeback path.
- Trades the single-cycle array for one add/shift per clock.
- Produces the full 64-bit product plus the same 32-bit-fit overflow flag as boot_prod.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH+1, Booth iterations (operands extended by one bit so MULTU shares the datapath).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin multiply; sampled only when idle or done
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- wr_hi  input  1  MTHI strobe
- wr_lo  input  1  MTLO strobe
- wr_data  input  WIDTH  MTHI/MTLO data
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse: hi/lo just updated by a multiply
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- of_flag  output  1  product does not fit in WIDTH bits

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, hi=0, lo=0, of_flag=0, iteration counter=0.
  - Reset mid-operation aborts the multiply; no partial result is written.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge N:
  - Latch M = a extended to WIDTH+1 bits (sign-extended if is_signed, else zero-extended).
  - Load P = {WIDTH+1 zeros, b extended the same way, 1'b0}.
  - Set count=0, enter RUN; busy=1 from this edge.
  - With start=0, DONE returns to IDLE.
- RUN, each edge:
  - Examine P[1:0]: 01 adds M to the upper WIDTH+1 bits, 10 subtracts M, 00/11 leave them unchanged.
  - Then arithmetic-shift P right by 1 and increment count.
- Edge N+ITER (the final iteration, N+33 at default):
  - {hi,lo} = low 2*WIDTH bits of the product.
  - of_flag: signed → hi != {WIDTH{lo[WIDTH-1]}}; unsigned → hi != 0.
  - State goes to DONE; busy=0, done=1 for exactly one cycle.
- Latency: result visible ITER cycles after the start edge. Throughput: one multiply per ITER+1 cycles; back-to-back start is allowed in DONE.
- start while busy is ignored; the latched operands are unaffected by changes on a/b/is_signed during RUN.
- wr_hi/wr_lo:
  - Write wr_data on the edge when busy=0; ignored while busy.
  - Both strobes together write both registers.
  - wr_* together with start in the same idle cycle: the write happens, then the multiply result overwrites at completion.
  - wr_* do not change of_flag.
- hi, lo and of_flag hold their value until the next completion, write or reset.

Test Plan:
- Reset, then a=0, b=0, is_signed=1, pulse start → done at start+33; hi=0, lo=0, of_flag=0; busy high for exactly 33 cycles.
- a=2, b=3, signed → lo=0x00000006, hi=0, of_flag=0.
- a=4388, b=-137, signed → lo=0xFFF6D3BC (-601156), hi=0xFFFFFFFF, of_flag=0.
- a=b=0xFFFFFFFF:
  - Signed → hi=0, lo=1, of_flag=0.
  - Unsigned → hi=0xFFFFFFFE, lo=0x00000001, of_flag=1.
- a=b=0x00010000, signed → hi=1, lo=0, of_flag=1.
- Protocol:
  - Start 2×3; pulse start with 5×5 at cycle 10 → ignored, result lo=6.
  - wr_lo=0xDEAD at cycle 12 → ignored.
  - After done, wr_hi=0x1234 → hi=0x1234.
  - Start again, drop rst_n at cycle 20 → immediately busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: operand/command and HI/LO result bundle
// for the sequential Booth multiplier.
interface booth_seq_mult_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             of_flag;

    modport master (
        output start, is_signed, a, b,
        output wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo, of_flag
    );

    modport slave (
        input  start, is_signed, a, b,
        input  wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo, of_flag
    );
endinterface

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: radix-2 Booth multiplier, one add/shift per clock,
// with architectural HI/LO registers for MULT/MULTU and MTHI/MTLO.
module booth_seq_mult #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_seq_mult_if.slave   bus
);
    localparam int PW = 2 * ITER + 1;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             last;
    logic [ITER-1:0]  m;
    logic [PW-1:0]    p;
    logic [PW-1:0]    p_acc;
    logic [PW-1:0]    p_nxt;
    logic [ITER-1:0]  acc;
    logic [CW-1:0]    cnt;
    logic             sgn;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             of_r;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic             of_nxt;
    logic [ITER-1:0]  a_x;
    logic [ITER-1:0]  b_x;
    logic             unused_bits;

    // One extra operand bit lets MULTU reuse the signed datapath.
    assign a_x = {bus.is_signed & bus.a[WIDTH-1], bus.a};
    assign b_x = {bus.is_signed & bus.b[WIDTH-1], bus.b};

    assign last = (cnt == CW'(ITER - 1));

    always_comb begin
        acc = p[PW-1 -: ITER];
        unique case (p[1:0])
            2'b01:   acc = p[PW-1 -: ITER] + m;
            2'b10:   acc = p[PW-1 -: ITER] - m;
            default: acc = p[PW-1 -: ITER];
        endcase
        p_acc = {acc, p[ITER:0]};
        p_nxt = {p_acc[PW-1], p_acc[PW-1:1]};
    end

    assign lo_nxt = p_nxt[WIDTH:1];
    assign hi_nxt = p_nxt[2*WIDTH:WIDTH+1];
    assign of_nxt = sgn ? (hi_nxt != {WIDTH{lo_nxt[WIDTH-1]}})
                        : (hi_nxt != '0);
    assign unused_bits = ^{p_nxt[PW-1:2*WIDTH+1], p_nxt[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                load      = bus.start;
                state_nxt = bus.start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    <= '0;
            p    <= '0;
            cnt  <= '0;
            sgn  <= 1'b0;
            hi_r <= '0;
            lo_r <= '0;
            of_r <= 1'b0;
        end else begin
            if (load) begin
                m   <= a_x;
                p   <= {{ITER{1'b0}}, b_x, 1'b0};
                cnt <= '0;
                sgn <= bus.is_signed;
            end else if (state == RUN) begin
                p   <= p_nxt;
                cnt <= cnt + CW'(1);
                if (last) begin
                    hi_r <= hi_nxt;
                    lo_r <= lo_nxt;
                    of_r <= of_nxt;
                end
            end
            // Moves share the cycle with a new start; the result lands later.
            if (state != RUN && bus.wr_hi) hi_r <= bus.wr_data;
            if (state != RUN && bus.wr_lo) lo_r <= bus.wr_data;
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.of_flag = of_r;
endmodule
